preg_free_list: RTL and testbench

//  Physical-register free list for the rename stage. Holds a NUM_PREGS-bit free bitmap.

---
 rtl/rename_pkg.sv | 7 +
 rtl/preg_free_list_priority_encoder.sv | 28 ++
 rtl/preg_free_list.sv | 95 +++++++++
 tb/tb_preg_free_list.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage sizing: physical/architectural register counts and the preg index type.
package rename_pkg;
  localparam int NUM_PREGS = 64;
  localparam int NUM_ARCH  = 32;
  localparam int PREG_W    = $clog2(NUM_PREGS);
  typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/preg_free_list_priority_encoder.sv
// Two-sided priority encoder: lowest and highest set bit of a vector, purely combinational.
// Outputs are zero when no bit is set; callers qualify them with their own occupancy count.
module priority_encoder
  import rename_pkg::*;
#(
  parameter int WIDTH    = NUM_PREGS,
  parameter bit TWO_SIDE = 1'b1
) (
  input  logic [WIDTH-1:0]         i_vec,
  output logic [$clog2(WIDTH)-1:0] out_LSB,
  output logic [$clog2(WIDTH)-1:0] out_MSB
);
  localparam int IW = $clog2(WIDTH);

  always_comb begin
    out_LSB = '0;
    out_MSB = '0;
    // Later hits overwrite earlier ones, so scan direction picks the winning end.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) out_LSB = IW'(i);
    end
    if (TWO_SIDE) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_vec[i]) out_MSB = IW'(i);
      end
    end
  end
endmodule

// File: rtl/preg_free_list.sv
// Physical-register free list: grants up to two pregs per cycle (lowest and highest free index),
// zero-cycle grant, commit at next edge; stalls (alloc_ready=0) on flush or insufficient free pregs.
module preg_free_list
  import rename_pkg::*;
#(
  parameter int NUM_PREGS = rename_pkg::NUM_PREGS,
  parameter int NUM_ARCH  = rename_pkg::NUM_ARCH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   alloc_req,
  output logic                         alloc_ready,
  output logic [$clog2(NUM_PREGS)-1:0] alloc_preg0,
  output logic [$clog2(NUM_PREGS)-1:0] alloc_preg1,
  input  logic [1:0]                   free_valid,
  input  logic [$clog2(NUM_PREGS)-1:0] free_preg0,
  input  logic [$clog2(NUM_PREGS)-1:0] free_preg1,
  input  logic                         flush_valid,
  input  logic [NUM_PREGS-1:0]         flush_mask,
  output logic [$clog2(NUM_PREGS):0]   free_count,
  output logic                         err_double_free
);
  localparam int IW = $clog2(NUM_PREGS);
  localparam int CW = IW + 1;
  localparam logic [NUM_PREGS-1:0] RESET_FREE = {{(NUM_PREGS - NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};
  localparam logic [NUM_PREGS-1:0] PREG0_BIT  = NUM_PREGS'(1);
  localparam logic [CW-1:0]        RESET_CNT  = CW'(NUM_PREGS - NUM_ARCH);

  logic [NUM_PREGS-1:0] r_free;
  logic [CW-1:0]        r_count;
  logic                 r_err;

  logic [1:0]           w_need;
  logic                 w_fire;
  logic [NUM_PREGS-1:0] w_free_nxt;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_err_hit;
  logic                 w_f0_live;
  logic                 w_f1_live;

  priority_encoder #(.WIDTH(NUM_PREGS), .TWO_SIDE(1'b1)) u_penc (
    .i_vec   (r_free),
    .out_LSB (alloc_preg0),
    .out_MSB (alloc_preg1)
  );

  assign w_need      = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
  assign alloc_ready = !flush_valid && (r_count >= CW'(w_need));
  assign w_fire      = (alloc_req != 2'b00) && alloc_ready;
  assign w_f0_live   = free_valid[0] && (free_preg0 != '0);
  assign w_f1_live   = free_valid[1] && (free_preg1 != '0);

  // Allocations clear first, then frees/flush set, so error checks look at the pre-cycle bitmap.
  always_comb begin
    w_free_nxt = r_free;
    w_err_hit  = 1'b0;
    if (w_fire && alloc_req[0]) w_free_nxt[alloc_preg0] = 1'b0;
    if (w_fire && alloc_req[1]) w_free_nxt[alloc_preg1] = 1'b0;
    if (w_f0_live) begin
      if (r_free[free_preg0]) w_err_hit = 1'b1;
      w_free_nxt[free_preg0] = 1'b1;
    end
    if (w_f1_live) begin
      if (r_free[free_preg1]) w_err_hit = 1'b1;
      w_free_nxt[free_preg1] = 1'b1;
    end
    if (w_f0_live && w_f1_live && (free_preg0 == free_preg1)) w_err_hit = 1'b1;
    if (flush_valid) begin
      if (|(flush_mask & r_free & ~PREG0_BIT)) w_err_hit = 1'b1;
      w_free_nxt = w_free_nxt | (flush_mask & ~PREG0_BIT);
    end
  end

  always_comb begin
    w_count_nxt = '0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      w_count_nxt = w_count_nxt + CW'(w_free_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_free  <= RESET_FREE;
      r_count <= RESET_CNT;
      r_err   <= 1'b0;
    end else begin
      r_free  <= w_free_nxt;
      r_count <= w_count_nxt;
      r_err   <= r_err | w_err_hit;
    end
  end

  assign free_count      = r_count;
  assign err_double_free = r_err;
endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: directed scenarios plus random traffic against a set-based free-list model.
module tb_preg_free_list;
  import rename_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0]           alloc_req;
  logic                 alloc_ready;
  logic [PREG_W-1:0]    alloc_preg0;
  logic [PREG_W-1:0]    alloc_preg1;
  logic [1:0]           free_valid;
  logic [PREG_W-1:0]    free_preg0;
  logic [PREG_W-1:0]    free_preg1;
  logic                 flush_valid;
  logic [NUM_PREGS-1:0] flush_mask;
  logic [PREG_W:0]      free_count;
  logic                 err_double_free;

  preg_free_list #(.NUM_PREGS(NUM_PREGS), .NUM_ARCH(NUM_ARCH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alloc_req       (alloc_req),
    .alloc_ready     (alloc_ready),
    .alloc_preg0     (alloc_preg0),
    .alloc_preg1     (alloc_preg1),
    .free_valid      (free_valid),
    .free_preg0      (free_preg0),
    .free_preg1      (free_preg1),
    .flush_valid     (flush_valid),
    .flush_mask      (flush_mask),
    .free_count      (free_count),
    .err_double_free (err_double_free)
  );

  typedef struct {
    bit chk;
    bit ready;
    bit fire;
    int p0;
    int p1;
    int cnt;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: a plain set of free preg numbers plus a sticky error flag.
  bit   m_free[NUM_PREGS];
  bit   m_err;
  bit   m_valid = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NUM_PREGS; i++) c += int'(m_free[i]);
    return c;
  endfunction

  task automatic drive(input logic r, input logic [1:0] req, input logic [1:0] fv,
                       input int fp0, input int fp1, input logic flv, input logic [NUM_PREGS-1:0] fm);
    exp_t e;
    int   lo;
    int   hi;
    int   need;
    bit   old[NUM_PREGS];
    @(posedge clk);
    #1;
    rst_n       = r;
    alloc_req   = req;
    free_valid  = fv;
    free_preg0  = PREG_W'(fp0);
    free_preg1  = PREG_W'(fp1);
    flush_valid = flv;
    flush_mask  = fm;

    lo = -1;
    hi = -1;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (m_free[i] && lo < 0) lo = i;
      if (m_free[i]) hi = i;
    end
    need    = int'(req[0]) + int'(req[1]);
    e.chk   = m_valid;
    e.cnt   = m_count();
    e.err   = m_err;
    e.ready = !flv && (e.cnt >= need);
    e.fire  = (req != 2'b00) && e.ready;
    e.p0    = lo;
    e.p1    = hi;
    sb.push_back(e);

    if (!r) begin
      for (int i = 0; i < NUM_PREGS; i++) m_free[i] = (i >= NUM_ARCH);
      m_err   = 0;
      m_valid = 1;
    end else begin
      old = m_free;
      if (e.fire && req[0]) m_free[lo] = 0;
      if (e.fire && req[1]) m_free[hi] = 0;
      if (fv[0] && fp0 != 0) begin
        if (old[fp0]) m_err = 1;
        m_free[fp0] = 1;
      end
      if (fv[1] && fp1 != 0) begin
        if (old[fp1]) m_err = 1;
        m_free[fp1] = 1;
      end
      if (fv == 2'b11 && fp0 == fp1 && fp0 != 0) m_err = 1;
      if (flv) begin
        for (int i = 1; i < NUM_PREGS; i++) begin
          if (fm[i]) begin
            if (old[i]) m_err = 1;
            m_free[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic idle(input logic [1:0] req);
    drive(1'b1, req, 2'b00, 0, 0, 1'b0, '0);
  endtask

  // Scoreboard monitor: one expectation per driven cycle, checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          cmp("sb_ready", 32'(alloc_ready), 32'(e.ready));
          cmp("sb_count", 32'(free_count), 32'(e.cnt));
          cmp("sb_err", 32'(err_double_free), 32'(e.err));
          if (e.fire) begin
            cmp("sb_preg0", 32'(alloc_preg0), 32'(e.p0));
            cmp("sb_preg1", 32'(alloc_preg1), 32'(e.p1));
          end
        end
      end
    end
  end

  initial begin
    logic [NUM_PREGS-1:0] m;
    int al[$];
    int f0;
    int f1;
    logic [1:0] fv;
    logic [1:0] rq;
    int pick;

    rst_n = 1'b0; alloc_req = '0; free_valid = '0; free_preg0 = '0; free_preg1 = '0;
    flush_valid = 1'b0; flush_mask = '0;
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, '0);
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, '0);

    // 1: first dual grant after reset
    idle(2'b11);
    @(negedge clk);
    cmp("t1_ready", 32'(alloc_ready), 1);
    cmp("t1_preg0", 32'(alloc_preg0), 32);
    cmp("t1_preg1", 32'(alloc_preg1), 63);
    idle(2'b00);
    @(negedge clk);
    cmp("t1_count", 32'(free_count), 30);

    // 2: drain to one free preg, double request stalls, single succeeds
    idle(2'b01);
    for (int k = 0; k < 14; k++) idle(2'b11);
    idle(2'b11);
    @(negedge clk);
    cmp("t2_count1", 32'(free_count), 1);
    cmp("t2_ready_dbl", 32'(alloc_ready), 0);
    idle(2'b01);
    @(negedge clk);
    cmp("t2_ready_sgl", 32'(alloc_ready), 1);
    cmp("t2_preg0", 32'(alloc_preg0), 48);
    cmp("t2_preg1", 32'(alloc_preg1), 48);
    idle(2'b00);
    @(negedge clk);
    cmp("t2_count0", 32'(free_count), 0);

    // 3: no same-cycle bypass of a freed preg
    drive(1'b1, 2'b01, 2'b01, 40, 0, 1'b0, '0);
    @(negedge clk);
    cmp("t3_ready_same", 32'(alloc_ready), 0);
    idle(2'b01);
    @(negedge clk);
    cmp("t3_ready_next", 32'(alloc_ready), 1);
    cmp("t3_preg0", 32'(alloc_preg0), 40);

    // 4: flush returns squashed pregs and blocks allocation that cycle
    drive(1'b1, 2'b00, 2'b11, 32, 33, 1'b0, '0);
    drive(1'b1, 2'b00, 2'b11, 34, 35, 1'b0, '0);
    idle(2'b11);
    idle(2'b11);
    m = '0;
    for (int i = 32; i <= 35; i++) m[i] = 1'b1;
    drive(1'b1, 2'b11, 2'b00, 0, 0, 1'b1, m);
    @(negedge clk);
    cmp("t4_ready_flush", 32'(alloc_ready), 0);
    idle(2'b01);
    @(negedge clk);
    cmp("t4_count", 32'(free_count), 4);
    cmp("t4_preg0", 32'(alloc_preg0), 32);

    // 5: double free is sticky and does not change count; preg 0 free is ignored
    drive(1'b1, 2'b00, 2'b01, 50, 0, 1'b0, '0);
    drive(1'b1, 2'b00, 2'b01, 50, 0, 1'b0, '0);
    @(negedge clk);
    cmp("t5_count_pre", 32'(free_count), 4);
    drive(1'b1, 2'b00, 2'b01, 0, 0, 1'b0, '0);
    @(negedge clk);
    cmp("t5_err", 32'(err_double_free), 1);
    cmp("t5_count_dbl", 32'(free_count), 4);
    idle(2'b00);
    @(negedge clk);
    cmp("t5_count_p0", 32'(free_count), 4);
    cmp("t5_err_hold", 32'(err_double_free), 1);

    // random traffic; reset clears the sticky error early on
    drive(1'b0, 2'b00, 2'b00, 0, 0, 1'b0, '0);
    for (int k = 0; k < 1500; k++) begin
      al.delete();
      for (int i = 1; i < NUM_PREGS; i++) if (!m_free[i]) al.push_back(i);
      fv = 2'b00; f0 = 0; f1 = 0;
      if (al.size() > 0 && $urandom_range(0, 9) < 4) begin
        pick = $urandom_range(0, al.size() - 1);
        fv[0] = 1'b1; f0 = al[pick];
        al.delete(pick);
      end
      if (al.size() > 0 && $urandom_range(0, 9) < 3) begin
        pick = $urandom_range(0, al.size() - 1);
        fv[1] = 1'b1; f1 = al[pick];
      end
      if ($urandom_range(0, 99) < 2) begin
        fv[0] = 1'b1; f0 = $urandom_range(0, NUM_PREGS - 1);
      end
      m = '0;
      if ($urandom_range(0, 99) < 5) begin
        for (int i = 0; i < NUM_PREGS; i++) if (!m_free[i] && $urandom_range(0, 3) == 0) m[i] = 1'b1;
        m[0] = 1'($urandom_range(0, 1));
      end
      case ($urandom_range(0, 2))
        0: rq = 2'b00;
        1: rq = 2'b01;
        default: rq = 2'b11;
      endcase
      drive(($urandom_range(0, 199) != 0), rq, fv, f0, f1, (m != '0), m);
    end

    // 6: reset mid-burst overrides alloc, free and flush
    m = '0;
    m[5] = 1'b1; m[40] = 1'b1;
    drive(1'b0, 2'b11, 2'b11, 7, 9, 1'b1, m);
    idle(2'b11);
    @(negedge clk);
    cmp("t6_count", 32'(free_count), 32);
    cmp("t6_err", 32'(err_double_free), 0);
    cmp("t6_ready", 32'(alloc_ready), 1);
    cmp("t6_preg0", 32'(alloc_preg0), 32);
    cmp("t6_preg1", 32'(alloc_preg1), 63);

    idle(2'b00);
    idle(2'b00);
    @(negedge clk);
    @(negedge clk);
    cmp("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
